mbus_busy_monitor: RTL

Always-on, parametrised bus-busy controller for the MBus layer controller, clocked from the local always-on oscillator. It synchronises the asynchronous MBus clock line and detects bus activity to drive `BUS_BUSYn` low. It releases busy from any of N maskable clear sources, some gated by power-isolation hold. An idle watchdog auto-releases a hung bus, and a guard window prevents immediate re-arming after release.

---
 rtl/mbus_busy_pkg.sv | 15 +
 rtl/mbus_sync_ff.sv | 32 +++
 rtl/mbus_busy_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mbus_busy_pkg.sv
// Shared definitions for the MBus bus-busy monitor: FSM state encoding and
// the isolation level that means "IO held".
package mbus_busy_pkg;

  // 2'd3 is not a legal state; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } busy_state_e;

  // Level of BC_RELEASE_ISO at which the IO is held in isolation.
  localparam logic IO_HOLD = 1'b1;

endpackage

// File: rtl/mbus_sync_ff.sv
// Parametrised N-stage synchroniser with asynchronous reset to a
// parameterised level. Used for asynchronous lines in the always-on domain.
module mbus_sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops; reset to the line's idle level so no edge is seen
  // when reset releases.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every stage samples the previous
    // stage's old value at the same edge; blocking would collapse the chain.
    if (rst) sync_q <= {STAGES{RESET_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mbus_busy_monitor.sv
// Bus-busy controller: detects MBus clock activity, drives BUS_BUSYn low,
// releases on maskable clear requests or an idle watchdog, then holds off
// re-arming until the line has been high for RELEASE_CYCLES samples.
module mbus_busy_monitor
  import mbus_busy_pkg::*;
#(
  parameter int                 NUM_CLR        = 2,
  parameter logic [NUM_CLR-1:0] ISO_GATED      = 2'b01,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 RELEASE_CYCLES = 4,
  parameter int                 TIMEOUT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MBUS_CLKIN,
  input  logic                 BC_RELEASE_ISO,
  input  logic [NUM_CLR-1:0]   CLR_BUSY,
  input  logic [NUM_CLR-1:0]   CLR_MASK,
  input  logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT,
  input  logic                 TIMEOUT_CLR,
  output logic                 BUS_BUSYn,
  output logic                 BUSY_TIMEOUT,
  output logic [1:0]           BUSY_STATE
);

  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

  logic                 line_sync;
  logic                 line_cur_q,  line_cur_d;
  logic                 line_prev_q, line_prev_d;
  busy_state_e          state_q,     state_d;
  logic                 busy_n_q,    busy_n_d;
  logic                 timeout_q,   timeout_d;
  logic [TIMEOUT_W-1:0] wd_q,        wd_d;
  logic [REL_W-1:0]     rel_cnt_q,   rel_cnt_d;

  logic             iso_hold;
  logic             clr_eff;
  logic             line_fall;
  logic             line_edge;
  logic             wd_expire;
  logic [REL_W-1:0] rel_inc;

  mbus_sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (MBUS_CLKIN),
    .q   (line_sync)
  );

  // Clear sources marked ISO_GATED are ignored while the IO is held.
  assign iso_hold  = (BC_RELEASE_ISO == IO_HOLD);
  assign clr_eff   = |(CLR_BUSY & CLR_MASK & ~(ISO_GATED & {NUM_CLR{iso_hold}}));
  assign line_fall = line_prev_q & ~line_cur_q;
  assign line_edge = line_prev_q ^ line_cur_q;
  // An edge in the would-be expiry cycle restarts the idle count instead.
  assign wd_expire = (TIMEOUT_LIMIT != '0) && !line_edge
                     && (wd_q == TIMEOUT_LIMIT - TIMEOUT_W'(1));
  assign rel_inc   = rel_cnt_q + REL_W'(1);

  // Next-state logic for the busy FSM, watchdog, release counter and flags.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned
    // and no latch is inferred.
    line_cur_d  = line_sync;
    line_prev_d = line_cur_q;
    state_d     = state_q;
    rel_cnt_d   = rel_cnt_q;
    timeout_d   = TIMEOUT_CLR ? 1'b0 : timeout_q;
    wd_d        = (wd_q == '1) ? wd_q : wd_q + TIMEOUT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (line_fall && !clr_eff) begin
          state_d = ST_BUSY;
          wd_d    = '0;
        end
      end
      ST_BUSY: begin
        if (line_edge) wd_d = '0;
        if (clr_eff) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
        end else if (wd_expire) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
          timeout_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!line_cur_q) begin
          rel_cnt_d = '0;
        end else if (rel_inc == REL_W'(RELEASE_CYCLES)) begin
          state_d   = ST_IDLE;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_n_d = (state_d != ST_BUSY);
  end

  // State and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_cur_q  <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      busy_n_q    <= 1'b1;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      rel_cnt_q   <= '0;
    end else begin
      line_cur_q  <= line_cur_d;
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      busy_n_q    <= busy_n_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
      rel_cnt_q   <= rel_cnt_d;
    end
  end

  assign BUS_BUSYn    = busy_n_q;
  assign BUSY_TIMEOUT = timeout_q;
  assign BUSY_STATE   = state_q;

endmodule
